// File: rtl/mult_div_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit with HI/LO.
package mult_div_pkg;

  localparam int unsigned ITER = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  // Wide enough to be sliced down to any operand width up to 64.
  localparam logic [63:0] DIV0_QUOT = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX
  } md_state_e;

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/md_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
module md_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_next,
  output logic               q_bit
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   partial;
  logic [WIDTH-1:0] diff;

  always_comb begin
    // Multiply: acc = {partial product, remaining multiplier bits}.
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    // Divide: acc = {remainder, remaining dividend bits}; shift one dividend bit in.
    partial = acc[2*WIDTH-1:WIDTH-1];
    diff    = partial[WIDTH-1:0] - operand;

    q_bit    = 1'b0;
    acc_next = {sum, acc[WIDTH-1:1]};
    if (is_div) begin
      q_bit    = (partial >= {1'b0, operand});
      // Quotient bit slot is left zero; the caller merges q_bit in.
      acc_next = {(q_bit ? diff : partial[WIDTH-1:0]), acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mult_div_hilo.sv
// Iterative multiply/divide unit writing HI/LO; MD_FAST_MULT_EN selects a single-cycle
// multiplier for MULT/MULTU while divides stay iterative.
module mult_div_hilo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  import mult_div_pkg::*;

  localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int unsigned DW = 2 * WIDTH;

  md_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             is_div_q, is_div_d;
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div0_q, div0_d;
  logic             done_q, done_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             is_md_op, launch;
  logic [DW-1:0]    step_acc;
  logic             step_qbit;
  logic [DW-1:0]    prod;
  logic [WIDTH-1:0] quot, rem, fix_hi, fix_lo;

  // Operands are reduced to magnitudes up front; sign is restored in ST_FIX.
  assign a_neg    = is_signed_op(op) & OpA[WIDTH-1];
  assign b_neg    = is_signed_op(op) & OpB[WIDTH-1];
  assign mag_a    = a_neg ? -OpA : OpA;
  assign mag_b    = b_neg ? -OpB : OpB;
  assign is_md_op = ~op[2];

  assign prod   = neg_quot_q ? -acc_q : acc_q;
  assign quot   = acc_q[WIDTH-1:0];
  assign rem    = acc_q[DW-1:WIDTH];
  assign fix_lo = div0_q ? DIV0_QUOT[WIDTH-1:0] : (neg_quot_q ? -quot : quot);
  assign fix_hi = neg_rem_q ? -rem : rem;

`ifdef MD_FAST_MULT_EN
  logic [DW-1:0] fast_mag, fast_prod;
  assign fast_mag  = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
  assign fast_prod = (a_neg ^ b_neg) ? -fast_mag : fast_mag;
`endif

  md_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc      (acc_q),
    .operand  (opb_q),
    .is_div   (is_div_q),
    .acc_next (step_acc),
    .q_bit    (step_qbit)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opb_d      = opb_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    is_div_d   = is_div_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    div0_d     = div0_q;
    done_d     = 1'b0;
    launch     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_md_op) begin
`ifdef MD_FAST_MULT_EN
            if (!op[1]) begin
              {hi_d, lo_d} = fast_prod;
              done_d       = 1'b1;
            end else begin
              launch = 1'b1;
            end
`else
            launch = 1'b1;
`endif
          end else if (op == OP_MTHI) begin
            hi_d = OpA;
          end else if (op == OP_MTLO) begin
            lo_d = OpA;
          end
        end
        if (launch) begin
          acc_d      = {{WIDTH{1'b0}}, mag_a};
          opb_d      = mag_b;
          is_div_d   = op[1];
          neg_quot_d = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          div0_d     = op[1] & (OpB == '0);
          cnt_d      = '0;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d = step_acc | {{(DW-1){1'b0}}, step_qbit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ITER - 1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        if (is_div_q) begin
          hi_d = fix_hi;
          lo_d = fix_lo;
        end else begin
          {hi_d, lo_d} = prod;
        end
        done_d  = 1'b1;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opb_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      is_div_q   <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      div0_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opb_q      <= opb_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      is_div_q   <= is_div_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      div0_q     <= div0_d;
      done_q     <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_mult_div_hilo.sv
// Self-checking bench for mult_div_hilo: directed corner cases plus random ops vs an
// arithmetic reference model.
module tb_mult_div_hilo;

  import mult_div_pkg::*;

  logic        clock;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] opa, opb;
  logic [31:0] hi, lo;
  logic        busy, done;

  int checks = 0;
  int errors = 0;

  mult_div_hilo #(
    .WIDTH (32)
  ) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .op    (op),
    .OpA   (opa),
    .OpB   (opb),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural values.
  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = '0;
    case (o)
      OP_MULT:  p = sa * sb;
      OP_MULTU: p = ua * ub;
      OP_DIV: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else p = {32'(sa % sb), 32'(sa / sb)};
      end
      OP_DIVU: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else p = {32'(ua % ub), 32'(ua / ub)};
      end
      default: p = '0;
    endcase
    eh = p[63:32];
    el = p[31:0];
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit inject);
    logic [31:0] eh, el;
    int lat, busy_cnt, exp_lat;
    model(o, a, b, eh, el);
    exp_lat = 33;
`ifdef MD_FAST_MULT_EN
    if (o == OP_MULT || o == OP_MULTU) exp_lat = 0;
`endif
    op    = o;
    opa   = a;
    opb   = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    // Operands are free to change once captured.
    opa      = $urandom;
    opb      = $urandom;
    lat      = 0;
    busy_cnt = 0;
    while (!done && lat < 200) begin
      if (busy) busy_cnt++;
      if (inject && lat == 5) begin
        start = 1'b1;
        op    = OP_DIVU;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
    end
    start = 1'b0;
    check_eq({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
    check_eq({tag, "_busy_in_done"}, 64'(busy), 64'd0);
    check_eq({tag, "_hi"}, 64'(hi), 64'(eh));
    check_eq({tag, "_lo"}, 64'(lo), 64'(el));
    tick();
    check_eq({tag, "_done_pulse"}, 64'(done), 64'd0);
    check_eq({tag, "_idle_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb, save_hi, save_lo;
    logic [2:0]  ro;

    reset = 1'b1;
    start = 1'b0;
    op    = '0;
    opa   = '0;
    opb   = '0;
    tick();
    tick();
    reset = 1'b0;
    check_eq("reset_hi", 64'(hi), 64'd0);
    check_eq("reset_lo", 64'(lo), 64'd0);
    check_eq("reset_busy", 64'(busy), 64'd0);
    check_eq("reset_done", 64'(done), 64'd0);

    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
    run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("divu_small", OP_DIVU, 32'd100, 32'd7, 1'b0);
    run_op("div_by_zero", OP_DIV, 32'h1234_5678, 32'd0, 1'b0);
    run_op("div_neg_by_zero", OP_DIV, 32'h8765_4321, 32'd0, 1'b0);
    run_op("div_overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("mult_big", OP_MULT, 32'h0001_0000, 32'h0001_0000, 1'b0);
    run_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, 1'b0);
    run_op("div_ignore_start", OP_DIV, 32'd1000, 32'hFFFF_FFFD, 1'b1);

    // MTHI then MTLO on consecutive edges.
    start = 1'b1;
    op    = OP_MTHI;
    opa   = 32'hAAAA_5555;
    tick();
    check_eq("mthi_hi", 64'(hi), 64'hAAAA_5555);
    check_eq("mthi_busy", 64'(busy), 64'd0);
    op  = OP_MTLO;
    opa = 32'h0F0F_0F0F;
    tick();
    start = 1'b0;
    check_eq("mtlo_lo", 64'(lo), 64'h0F0F_0F0F);
    check_eq("mtlo_hi_kept", 64'(hi), 64'hAAAA_5555);
    check_eq("mtlo_busy", 64'(busy), 64'd0);
    check_eq("mtlo_done", 64'(done), 64'd0);

    // NOP encodings leave everything alone.
    for (int i = 0; i < 2; i++) begin
      start = 1'b1;
      op    = (i == 0) ? 3'b110 : 3'b111;
      opa   = $urandom;
      opb   = $urandom;
      tick();
      start = 1'b0;
      check_eq("nop_hi", 64'(hi), 64'hAAAA_5555);
      check_eq("nop_lo", 64'(lo), 64'h0F0F_0F0F);
      check_eq("nop_busy", 64'(busy), 64'd0);
      check_eq("nop_done", 64'(done), 64'd0);
    end

    // Reset in the middle of an iterative op discards it.
    start = 1'b1;
    op    = OP_DIV;
    opa   = 32'hDEAD_BEEF;
    opb   = 32'h0000_1234;
    tick();
    start = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("midreset_hi", 64'(hi), 64'd0);
    check_eq("midreset_lo", 64'(lo), 64'd0);
    check_eq("midreset_busy", 64'(busy), 64'd0);
    check_eq("midreset_done", 64'(done), 64'd0);
    run_op("multu_after_reset", OP_MULTU, 32'd6, 32'd7, 1'b0);

    // Random ops with a bias toward the awkward divisors.
    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        3:       rb = ra;
        default: rb = $urandom;
      endcase
      run_op("rand", ro, ra, rb, i[0]);
    end

    // MTHI must not disturb LO, even after random results.
    save_lo = lo;
    save_hi = $urandom;
    start   = 1'b1;
    op      = OP_MTHI;
    opa     = save_hi;
    tick();
    start = 1'b0;
    check_eq("final_mthi_hi", 64'(hi), 64'(save_hi));
    check_eq("final_mthi_lo", 64'(lo), 64'(save_lo));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_div_hilo.md
Name: mult_div_hilo

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers, directly downstream of the register file.
- Consumes the two register-file read operands and produces 64-bit products, or quotient and remainder, into HI/LO for later MFHI/MFLO.
- Iterative radix-2: one bit per cycle, so the control unit stalls on busy.

Parameters:
- WIDTH, 32, operand width; HI/LO are each WIDTH bits.
- ITER, WIDTH, iteration count per operation (fixed equal to WIDTH).

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x NOP
- OpA  input  WIDTH  rs operand (multiplicand/dividend/MTHI-MTLO source)
- OpB  input  WIDTH  rt operand (multiplier/divisor)
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- busy  output  1  high while an iterative op is in flight
- done  output  1  one-cycle pulse when HI/LO take a mult/div result

Behaviour:
- Reset: state IDLE, hi=0, lo=0, busy=0, done=0, internal accumulators and counter 0. Reset mid-operation aborts; no partial result reaches HI/LO.
- States: IDLE, RUN, FIX. busy = (state != IDLE). done is registered and high only in the cycle after the FIX→IDLE edge.
- IDLE, start=1, op MULT/MULTU/DIV/DIVU, at edge k:
  - Latch |OpA| and |OpB| (signed ops) or raw values (unsigned ops).
  - Latch result-sign flags; counter=0; go to RUN.
- RUN: one shift-add (mult) or restoring shift-subtract (div) step per edge. At edge k+32 (counter==ITER-1) go to FIX.
- FIX, edge k+33: apply sign correction and write HI/LO; done=1 for one cycle; return to IDLE. busy is low in the done cycle. The next start may be accepted at edge k+33 or later.
- Latency: start edge k, result visible in the cycle after edge k+33.
- Multiply: {hi,lo} = full 64-bit product. Signed product is negated iff OpA and OpB signs differ.
- Divide: lo = quotient, hi = remainder. Signed quotient is negated iff signs differ. Remainder takes the dividend's sign.
- Divide by zero: lo = all ones, hi = OpA (original, unmodified). Still takes the full 33 cycles.
- Signed overflow (0x80000000 / 0xFFFFFFFF): lo = 0x80000000, hi = 0. This falls out of the unsigned-magnitude datapath with no special case.
- MTHI/MTLO with start=1 in IDLE: hi (resp. lo) = OpA at the same edge; busy stays 0; done stays 0.
- NOP ops: no effect.
- start while busy=1: ignored, not queued; operands are not re-sampled.
- Operands are captured at the start edge; OpA/OpB changes during RUN have no effect.

Optional Feature:
- Macro MD_FAST_MULT_EN.
- Defined: MULT/MULTU are computed with a single-cycle 64-bit multiplier. HI/LO are written at edge k, done=1 the following cycle, busy never rises. DIV/DIVU are unchanged.
- Undefined: all ops use the iterative 33-cycle path above; no hardware multiplier is inferred.

Decomposition:
- Package mult_div_pkg holds:
  - op encodings (OP_MULT … OP_MTLO);
  - state encoding (ST_IDLE, ST_RUN, ST_FIX);
  - ITER constant;
  - DIV0_QUOT constant (all ones).
- One natural sub-module, md_step: purely combinational single iteration. It takes the accumulator, operand and mode, and returns the next accumulator plus quotient bit. It is instantiated once inside mult_div_hilo.

Test Plan:
- Reset, then MULTU 0xFFFFFFFF×0xFFFFFFFF → after 33 cycles hi=0xFFFFFFFE, lo=0x00000001, done pulse 1 cycle, busy high exactly cycles k+1..k+33.
- MULT -3×7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 → lo=14, hi=2.
- DIV 0x12345678/0 → lo=0xFFFFFFFF, hi=0x12345678; DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI 0xAAAA5555 then MTLO 0x0F0F0F0F on consecutive edges → hi/lo update next cycle, busy=0, done=0; start asserted with DIVU mid-RUN of prior op is ignored; result matches the first op only.
- Assert reset at cycle 10 of a MULT → hi=lo=0, busy=0, done=0 next cycle; new MULTU 6×7 afterwards → lo=42, hi=0.
- With MD_FAST_MULT_EN: MULT 0x10000×0x10000 → hi=1, lo=0 one cycle after start, busy never high; DIVU 9/3 still takes 33 cycles → lo=3, hi=0.
